cpu_sequencer: RTL and testbench

- Multi-cycle sequencer for the 32-bit CPU. Owns the PC and instruction register (IR) and fetches over a req/ready instruction-memory handshake.
- Presents IR to the combinational instruction controller, then steps the datapath through decode, execute, optional memory access and writeback.
- Resolves jz/jg branches and parks the core in HALTED when the controller flags an unknown instruction.
- Sits between instruction/data memories, the controller, the register file write port and the ALU flags.

---
 rtl/cpu_sequencer.sv | 105 ++++++++++
 tb/tb_cpu_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 32-bit core.
// Owns PC, IR and the retired-instruction counter; control outputs are registered.
module cpu_sequencer #(
    parameter int N = 32,
    parameter int M = 16,
    parameter logic [M-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [M-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [N-1:0] imem_data,
    output logic [N-1:0] instr,
    input  logic         is_halted,
    input  logic         mem_read,
    input  logic         is_jz,
    input  logic         is_jg,
    input  logic [N-1:0] imm,
    input  logic         alu_zero,
    input  logic         alu_neg,
    output logic         dmem_req,
    input  logic         dmem_ack,
    output logic         reg_we,
    output logic [M-1:0] pc,
    output logic [31:0]  retired,
    output logic         halted,
    output logic [2:0]   state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    logic [2:0]   r_state;
    logic [M-1:0] r_pc;
    logic [N-1:0] r_instr;
    logic [31:0]  r_retired;
    logic         r_halted;
    logic         r_imem_req;
    logic         r_dmem_req;
    logic         r_reg_we;

    logic [2:0]   w_next;
    logic         w_taken;
    logic         w_branch;
    logic         w_unused;

    assign w_branch = is_jz | is_jg;
    assign w_taken  = (is_jz & alu_zero) | (is_jg & ~alu_zero & ~alu_neg);
    assign w_unused = ^imm[N-1:M];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (imem_ready) w_next = S_DECODE;
            S_DECODE: w_next = is_halted ? S_HALTED : S_EXEC;
            S_EXEC:   w_next = mem_read ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_FETCH;
        endcase
    end

    // Request/enable outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_retired  <= '0;
            r_halted   <= 1'b0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_reg_we   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_imem_req <= (w_next == S_FETCH);
            r_dmem_req <= (w_next == S_MEM);
            r_reg_we   <= (w_next == S_WB) & ~w_branch;
            r_halted   <= (w_next == S_HALTED);
            if (r_state == S_FETCH && imem_ready)
                r_instr <= imem_data;
            if (r_state == S_WB) begin
                r_pc      <= w_taken ? imm[M-1:0] : r_pc + 1'b1;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign dmem_req  = r_dmem_req;
    assign reg_we    = r_reg_we;
    assign pc        = r_pc;
    assign retired   = r_retired;
    assign halted    = r_halted;
    assign state     = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table-driven instructions with a writeback
// scoreboard, plus hand-written reset/fetch/mid-MEM-reset sequences.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        is_halted;
    logic        mem_read;
    logic        is_jz;
    logic        is_jg;
    logic [31:0] imm;
    logic        alu_zero;
    logic        alu_neg;
    logic        dmem_req;
    logic        dmem_ack;
    logic        reg_we;
    logic [15:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic [2:0]  state;

    cpu_sequencer #(.N(32), .M(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_data(imem_data), .instr(instr),
        .is_halted(is_halted), .mem_read(mem_read), .is_jz(is_jz), .is_jg(is_jg),
        .imm(imm), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .reg_we(reg_we),
        .pc(pc), .retired(retired), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          fwait;
        logic        halt;
        logic        mrd;
        int          dwait;
        logic        jz;
        logic        jg;
        logic        z;
        logic        n;
        logic [15:0] imm;
        logic [15:0] exp_pc;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic        we;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[11];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_ret;
    logic [15:0] cur_pc;
    logic        after_reset;
    logic        wb_seen = 1'b0;
    logic        wb_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctrl();
        is_halted = 1'b0; mem_read = 1'b0; is_jz = 1'b0; is_jg = 1'b0;
        imm = 32'h0; alu_zero = 1'b0; alu_neg = 1'b0;
    endtask

    // Writeback monitor: a WB cycle is scored on the following cycle, once pc/retired have moved.
    always @(negedge clk) begin
        if (rst) begin
            wb_seen = 1'b0;
        end else if (state == 3'd4) begin
            wb_seen = 1'b1;
            wb_we   = reg_we;
        end else if (wb_seen) begin
            wb_seen = 1'b0;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_pc", 32'(pc), 32'(mon_e.pc));
                check("wb_reg_we", 32'(wb_we), 32'(mon_e.we));
                check("wb_retired", retired, mon_e.ret);
                $display("[TB] retire #%0d pc=%h reg_we=%0b", retired, pc, wb_we);
            end
        end
    end

    task automatic push_exp(input logic [15:0] p, input logic we, input logic [31:0] r);
        exp_t e;
        e.pc = p; e.we = we; e.ret = r;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        int          k;
        int          reqcnt;
        int          dcnt;
        logic [31:0] prev_instr;
        k = 0;
        while (state != 3'd0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (state != 3'd0) check("wait_fetch", 32'(state), 32'd0);
        imem_data  = v.data;
        prev_instr = instr;
        reqcnt     = 0;
        for (int i = 0; i <= v.fwait; i++) begin
            imem_ready = (i == v.fwait);
            check("imem_addr", 32'(imem_addr), 32'(cur_pc));
            if (i > 0) check("instr_hold", instr, prev_instr);
            if (imem_req) reqcnt++;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        imem_data  = 32'hDEADBEEF;
        if (!after_reset) check("imem_req_cycles", 32'(reqcnt), 32'(v.fwait + 1));
        after_reset = 1'b0;
        check("decode_state", 32'(state), 32'd1);
        check("instr", instr, v.data);
        is_halted = v.halt; mem_read = v.mrd; is_jz = v.jz; is_jg = v.jg;
        imm = {16'h0, v.imm}; alu_zero = v.z; alu_neg = v.n;
        if (!v.halt) begin
            model_ret = model_ret + 32'd1;
            push_exp(v.exp_pc, v.exp_we, model_ret);
        end
        $display("[TB] issue instr=%h pc=%h", v.data, cur_pc);
        @(negedge clk);
        if (v.halt) begin
            check("halt_state", 32'(state), 32'd5);
            check("halted", 32'(halted), 32'd1);
            reqcnt = 0;
            for (int i = 0; i < 20; i++) begin
                if (imem_req || dmem_req || reg_we) reqcnt++;
                imem_ready = 1'b1;
                dmem_ack   = 1'b1;
                @(negedge clk);
            end
            imem_ready = 1'b0;
            dmem_ack   = 1'b0;
            check("halt_no_req", 32'(reqcnt), 32'd0);
            check("halt_pc", 32'(pc), 32'(cur_pc));
            check("halt_retired", retired, model_ret);
            check("halt_stays", 32'(state), 32'd5);
            clear_ctrl();
            return;
        end
        check("exec_state", 32'(state), 32'd2);
        @(negedge clk);
        if (v.mrd) begin
            dcnt = 0;
            for (int i = 0; i <= v.dwait; i++) begin
                dmem_ack = (i == v.dwait);
                check("mem_state", 32'(state), 32'd3);
                if (dmem_req) dcnt++;
                @(negedge clk);
            end
            dmem_ack = 1'b0;
            check("dmem_req_cycles", 32'(dcnt), 32'(v.dwait + 1));
        end
        check("wb_state", 32'(state), 32'd4);
        check("dmem_req_in_wb", 32'(dmem_req), 32'd0);
        @(negedge clk);
        clear_ctrl();
        cur_pc = v.exp_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] we_bits;
        //           data         fw h  m  dw jz jg z  n  imm       exp_pc    we
        vecs[0]  = '{32'h20030001, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0003, 1};
        vecs[1]  = '{32'h8C040002, 0, 0, 1, 2, 0, 0, 0, 0, 16'h0000, 16'h0004, 1};
        vecs[2]  = '{32'h10000010, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0010, 16'h0010, 0};
        vecs[3]  = '{32'h10000010, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0010, 16'h0011, 0};
        vecs[4]  = '{32'h14000040, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0040, 16'h0040, 0};
        vecs[5]  = '{32'h14000040, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0040, 16'h0041, 0};
        vecs[6]  = '{32'h18000080, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0080, 16'h0080, 0};
        vecs[7]  = '{32'h1000FFFF, 0, 0, 0, 0, 1, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0};
        vecs[8]  = '{32'h20050007, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1};
        vecs[9]  = '{32'h8C060001, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 1};
        vecs[10] = '{32'hFC000000, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0};

        rst = 1'b1; imem_ready = 1'b0; imem_data = 32'h0; dmem_ack = 1'b0;
        clear_ctrl();
        model_ret = 32'd0; cur_pc = 16'h0; after_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_reqs", 32'({imem_req, dmem_req, reg_we}), 32'd0);
        rst = 1'b0;

        // Back-to-back zero-wait fetch of two plain instructions.
        imem_ready = 1'b1;
        imem_data  = 32'h20010005;
        push_exp(16'h0001, 1'b1, 32'd1);
        push_exp(16'h0002, 1'b1, 32'd2);
        model_ret = 32'd2;
        we_bits = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) check("seq_addr0", 32'(imem_addr), 32'd0);
            if (c == 5) begin
                check("seq_addr1", 32'(imem_addr), 32'd1);
                imem_data = 32'h20020003;
            end
            we_bits[c-1] = reg_we;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        check("seq_reg_we_cycles", 32'(we_bits), 32'h88);
        check("seq_instr", instr, 32'h20020003);
        cur_pc = 16'h0002;
        after_reset = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset out of HALTED.
        rst = 1'b1;
        #1;
        check("unhalt_state", 32'(state), 32'd0);
        check("unhalt_pc", 32'(pc), 32'd0);
        check("unhalt_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_ret = 32'd0;

        // Reset mid-MEM must abort without writeback.
        imem_ready = 1'b1; imem_data = 32'h8C070003;
        @(negedge clk);
        imem_ready = 1'b0; mem_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mm_state", 32'(state), 32'd3);
        check("mm_dmem_req", 32'(dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mm_dmem_req_drop", 32'(dmem_req), 32'd0);
        check("mm_state_rst", 32'(state), 32'd0);
        check("mm_retired", retired, 32'd0);
        check("mm_reg_we", 32'(reg_we), 32'd0);
        @(negedge clk);
        rst = 1'b0; clear_ctrl();
        repeat (3) @(negedge clk);
        check("mm_no_wb", 32'(retired), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
